// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump engine: FSM encoding and
// the default register-file geometry.
package regfile_dump_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_dump_word_serializer.sv
// Turns one captured word into a byte stream, MSB byte first, on a
// valid/ready interface; flags the acceptance of the word's last byte.
module word_serializer
  import regfile_dump_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  input  logic              ready,
  output logic              valid,
  output logic [7:0]        data,
  output logic              word_done
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST_B = BCNT_W'(NBYTES - 1);

  logic [DATA_W-1:0] shreg;
  logic [BCNT_W-1:0] bcnt;

  assign data      = shreg[DATA_W-1 -: 8];
  assign word_done = valid && ready && (bcnt == LAST_B);

  // The last byte is not shifted out so out_data stays stable until the next load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg <= '0;
      bcnt  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      shreg <= word;
      bcnt  <= '0;
      valid <= 1'b1;
    end else if (valid && ready) begin
      if (bcnt == LAST_B) begin
        valid <= 1'b0;
      end else begin
        shreg <= shreg << 8;
        bcnt  <= bcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// Debug engine that walks a register range through a spare read port and
// streams each word out as bytes for the UART transmitter.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] lim;
  logic              load;
  logic              word_done;

  // The read port is addressed straight from the counter, so the word is
  // captured in LOAD and the address stays put through the word's SEND.
  assign load    = (state == LOAD);
  assign rf_addr = addr;

  word_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .word      (rf_data),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (out_data),
    .word_done (word_done)
  );

  // addr == lim is tested before incrementing, so lim at the top of the
  // address space ends the dump without wrapping addr back to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr  <= '0;
      lim   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (first_reg <= last_reg) begin
              addr  <= first_reg;
              lim   <= last_reg;
              busy  <= 1'b1;
              state <= LOAD;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        LOAD: begin
          state <= SEND;
        end
        SEND: begin
          if (word_done) begin
            if (addr == lim) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              addr  <= addr + 1'b1;
              state <= LOAD;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a register-array model feeds the read
// port and an expected-byte queue is checked against every accepted byte.
module tb_regfile_dump;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] first_reg = '0;
  logic [AW-1:0] last_reg = '0;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_data;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [32];
  assign rf_data = regs[rf_addr];

  typedef struct {
    logic [7:0]    b;
    logic [AW-1:0] a;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int stall_cnt = 0;
  bit bp_mode = 1'b0;
  bit allow_empty_done = 1'b0;
  int bp_idx = 0;
  logic [4:0] bp_pat = 5'b10010;  // ready sequence 0,1,0,0,1 (bit 0 first)

  regfile_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_word(input logic [AW-1:0] a, input logic [DW-1:0] w);
    for (int k = DW/8 - 1; k >= 0; k--) exp_q.push_back('{b: w[k*8 +: 8], a: a});
  endtask

  task automatic push_range(input int f, input int l);
    for (int a = f; a <= l; a++) push_word(AW'(a), regs[a]);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns one step after the edge that samples start.
  task automatic pulse_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
    @(posedge clk);
    #1;
    start = 1'b1;
    first_reg = f;
    last_reg = l;
    @(posedge clk);
    #1;
    start = 1'b0;
    first_reg = 5'd31;
    last_reg = 5'd0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, seen, 1);
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      out_ready = bp_pat[bp_idx];
      bp_idx = (bp_idx == 4) ? 0 : bp_idx + 1;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Per-cycle compare against the expected-byte queue and handshake rules.
  bit         pv = 1'b0;
  bit         pr = 1'b0;
  logic [7:0] pd = '0;
  bit         exp_done_next = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      pv = 1'b0;
      pr = 1'b0;
      exp_done_next = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, pd);
      end
      if (exp_done_next) check("done_after_last_byte", done, 1);
      else if (!allow_empty_done) check("no_spurious_done", done, 0);
      exp_done_next = 1'b0;
      if (done) begin
        done_cnt++;
        check("busy_low_in_done", busy, 0);
        check("valid_low_in_done", out_valid, 0);
      end
      if (!busy) check("valid_low_when_idle", out_valid, 0);
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_byte: got 0x%0h, expected no byte at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("stream_byte", out_data, e.b);
          check("stream_rf_addr", rf_addr, e.a);
          if (exp_q.size() == 0) exp_done_next = 1'b1;
        end
      end
      if (out_valid && !out_ready) stall_cnt++;
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
    end
  end

  initial begin
    int base_d;
    int base_x;
    int st;
    bit reached;

    for (int i = 0; i < 32; i++) regs[i] = '0;

    // Reset state
    cyc(3);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    cyc(2);

    // Single register, exact latency
    regs[5] = 32'hDEADBEEF;
    push_word(5'd5, regs[5]);
    check("model_r5_msb", exp_q[0].b, 8'hDE);
    check("model_r5_lsb", exp_q[3].b, 8'hEF);
    base_d = done_cnt;
    pulse_start(5'd5, 5'd5);
    check("load_busy", busy, 1);
    check("load_valid_low", out_valid, 0);
    check("load_rf_addr", rf_addr, 5);
    cyc(1);
    check("first_valid", out_valid, 1);
    check("first_byte", out_data, 8'hDE);
    cyc(4);
    check("single_done", done, 1);
    check("single_busy_low", busy, 0);
    cyc(1);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
    check("single_done_count", done_cnt, base_d + 1);

    // Full range including r0 and r31
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    push_range(0, 31);
    check("model_range_len", exp_q.size(), 128);
    check("model_range_b7", exp_q[7].b, 8'h01);
    check("model_range_b127", exp_q[127].b, 8'h1F);
    base_d = done_cnt;
    pulse_start(5'd0, 5'd31);
    wait_done(800, "range_done");
    cyc(3);
    check("range_all_bytes", exp_q.size(), 0);
    check("range_one_done", done_cnt, base_d + 1);
    check("range_idle", busy, 0);

    // Backpressure
    regs[3] = 32'h11223344;
    exp_q.push_back('{b: 8'h11, a: 5'd3});
    exp_q.push_back('{b: 8'h22, a: 5'd3});
    exp_q.push_back('{b: 8'h33, a: 5'd3});
    exp_q.push_back('{b: 8'h44, a: 5'd3});
    st = stall_cnt;
    bp_mode = 1'b1;
    pulse_start(5'd3, 5'd3);
    wait_done(100, "bp_done");
    bp_mode = 1'b0;
    cyc(2);
    check("bp_all_bytes", exp_q.size(), 0);
    check("bp_stalls_seen", stall_cnt > st, 1);

    // Empty range
    base_d = done_cnt;
    base_x = xfer_cnt;
    allow_empty_done = 1'b1;
    pulse_start(5'd7, 5'd2);
    check("empty_done", done, 1);
    check("empty_valid_low", out_valid, 0);
    cyc(1);
    allow_empty_done = 1'b0;
    check("empty_done_pulse", done, 0);
    cyc(3);
    check("empty_done_count", done_cnt, base_d + 1);
    check("empty_no_bytes", xfer_cnt, base_x);

    // Start ignored while busy
    regs[1] = 32'hCAFEF00D;
    regs[2] = 32'h0BADC0DE;
    push_range(1, 2);
    base_d = done_cnt;
    pulse_start(5'd1, 5'd2);
    cyc(3);
    pulse_start(5'd9, 5'd9);
    wait_done(100, "ign_done");
    cyc(10);
    check("ign_all_bytes", exp_q.size(), 0);
    check("ign_one_done", done_cnt, base_d + 1);
    check("ign_idle", busy, 0);

    // Snapshot semantics
    regs[4] = 32'h01020304;
    regs[5] = 32'h0A0B0C0D;
    push_word(5'd4, 32'h01020304);
    push_word(5'd5, 32'h55555555);
    pulse_start(5'd4, 5'd5);
    cyc(1);
    regs[4] = 32'hAAAAAAAA;
    regs[5] = 32'h55555555;
    wait_done(100, "snap_done");
    cyc(2);
    check("snap_all_bytes", exp_q.size(), 0);

    // Reset mid-dump, then a fresh dump
    for (int i = 8; i < 12; i++) regs[i] = 32'h80000000 | 32'(i * 16'h0101);
    push_range(8, 11);
    base_x = xfer_cnt;
    base_d = done_cnt;
    reached = 1'b0;
    pulse_start(5'd8, 5'd11);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (xfer_cnt >= base_x + 2) begin
        reached = 1'b1;
        break;
      end
    end
    check("rst_two_bytes_sent", reached, 1);
    reset = 1'b0;
    #1;
    check("abort_rf_addr", rf_addr, 0);
    check("abort_valid", out_valid, 0);
    check("abort_data", out_data, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    exp_q.delete();
    cyc(3);
    check("abort_no_done", done_cnt, base_d);
    reset = 1'b1;
    cyc(2);
    check("abort_stays_idle", busy, 0);
    push_range(8, 11);
    pulse_start(5'd8, 5'd11);
    wait_done(100, "restart_done");
    cyc(2);
    check("restart_all_bytes", exp_q.size(), 0);
    check("restart_one_done", done_cnt, base_d + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
